// File: rtl/sad_accumulator_if.sv
// sad_accumulator_if
//   Groups the sample-input and result-output handshakes of the SAD
//   accumulator.
//
//   Signals:
//     in_valid   producer -> accumulator   diff holds a sample
//     in_ready   accumulator -> producer   a sample can be taken this cycle
//     diff       producer -> accumulator   sign-magnitude difference word (N bits)
//     out_valid  accumulator -> consumer   sad holds a completed block result
//     out_ready  consumer -> accumulator   consumer takes the result
//     sad        accumulator -> consumer   block SAD, zero-extended
//     sad_sat    accumulator -> consumer   accumulator saturated during the block
//
//   Modports:
//     slave   the accumulator side
//     master  the environment side (producer + consumer)
interface sad_accumulator_if #(
   parameter int unsigned N = 32
);
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] diff;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] sad;
   logic         sad_sat;

   modport slave (
      input  in_valid,
      input  diff,
      input  out_ready,
      output in_ready,
      output out_valid,
      output sad,
      output sad_sat
   );

   modport master (
      output in_valid,
      output diff,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  sad,
      input  sad_sat
   );
endinterface

// File: rtl/sad_accumulator.sv
// sad_accumulator
//   Sums the magnitudes of sign-magnitude difference words (bit 15 = sign,
//   bits 14:0 = magnitude, bits N-1:16 ignored) over a block of BLOCK_LEN
//   accepted samples and presents one SAD result per block.
//
//   Parameters:
//     N          data word width (matches the subtract unit output)
//     BLOCK_LEN  samples per block, 2..256
//     ACC_W      accumulator width, 16..N
//
//   Ports:
//     clk    clock, all state changes on the rising edge
//     rst_n  synchronous active-low reset
//     flush  synchronous abort of the current block; wins over any handshake
//     bus    sad_accumulator_if.slave (sample input and result output)
//
//   Build option:
//     SAD_ACC_SAT_EN  defined: saturating add with sticky sad_sat flag
//                     undefined: add wraps modulo 2^ACC_W, sad_sat tied low
module sad_accumulator #(
   parameter int unsigned N         = 32,
   parameter int unsigned BLOCK_LEN = 16,
   parameter int unsigned ACC_W     = 20
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   sad_accumulator_if.slave  bus
);

   // Wide enough to hold BLOCK_LEN itself, so the counter never wraps.
   localparam int unsigned        CNT_W     = $clog2(BLOCK_LEN + 1);
   localparam logic [CNT_W-1:0]   BLOCK_CNT = CNT_W'(BLOCK_LEN);

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      OUT
   } state_t;

   state_t             state_q, state_d;
   logic [ACC_W-1:0]   acc_q,   acc_d;
   logic [CNT_W-1:0]   cnt_q,   cnt_d;

   logic [14:0]        mag;
   logic               in_rdy;
   logic               accept;
   logic [ACC_W-1:0]   acc_add;
   logic [CNT_W-1:0]   cnt_inc;

   // Sign bit and upper bits carry no information for the SAD.
   logic               unused_diff_bits;
   assign unused_diff_bits = ^{bus.diff[N-1:16], bus.diff[15]};

   assign mag     = bus.diff[14:0];
   assign in_rdy  = (state_q != OUT);
   assign accept  = bus.in_valid & in_rdy & ~flush;
   assign cnt_inc = cnt_q + CNT_W'(1);

`ifdef SAD_ACC_SAT_EN
   localparam int unsigned SUM_W = ACC_W + 1;

   logic               sat_q, sat_d;
   logic [SUM_W-1:0]   sum_full;
   logic               add_ovf;

   // One extra bit catches the carry out; a clamped accumulator stays
   // clamped because any non-zero add overflows again.
   assign sum_full = {1'b0, acc_q} + SUM_W'(mag);
   assign add_ovf  = sum_full[ACC_W];
   assign acc_add  = add_ovf ? '1 : sum_full[ACC_W-1:0];
`else
   assign acc_add  = acc_q + ACC_W'(mag);
`endif

   // Next-state and datapath update. IDLE and ACCUM share the add path:
   // in IDLE the accumulator and counter are already zero, so the first
   // sample simply loads its magnitude and sets the count to one.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
`ifdef SAD_ACC_SAT_EN
      sat_d   = sat_q;
`endif

      unique case (state_q)
         IDLE, ACCUM: begin
            if (accept) begin
               acc_d   = acc_add;
               cnt_d   = cnt_inc;
`ifdef SAD_ACC_SAT_EN
               sat_d   = sat_q | add_ovf;
`endif
               state_d = (cnt_inc == BLOCK_CNT) ? OUT : ACCUM;
            end
         end
         OUT: begin
            if (bus.out_ready) begin
               state_d = IDLE;
               acc_d   = '0;
               cnt_d   = '0;
`ifdef SAD_ACC_SAT_EN
               sat_d   = 1'b0;
`endif
            end
         end
         default: begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
`ifdef SAD_ACC_SAT_EN
            sat_d   = 1'b0;
`endif
         end
      endcase

      // Abort overrides whatever handshake happened this cycle.
      if (flush) begin
         state_d = IDLE;
         acc_d   = '0;
         cnt_d   = '0;
`ifdef SAD_ACC_SAT_EN
         sat_d   = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
`ifdef SAD_ACC_SAT_EN
         sat_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
`ifdef SAD_ACC_SAT_EN
         sat_q   <= sat_d;
`endif
      end
   end

   // Handshake outputs come only from registered state.
   assign bus.in_ready  = in_rdy;
   assign bus.out_valid = (state_q == OUT);
   assign bus.sad       = N'(acc_q);
`ifdef SAD_ACC_SAT_EN
   assign bus.sad_sat   = sat_q;
`else
   assign bus.sad_sat   = 1'b0;
`endif

endmodule

// File: tb/tb_sad_accumulator.sv
// tb_sad_accumulator
//   Self-checking bench for sad_accumulator. A default-parameter instance
//   is compared every checked cycle against a reference model holding the
//   accepted magnitudes of the current block in a queue; a second instance
//   (BLOCK_LEN = 4, ACC_W = 16) covers the overflow behaviour.
module tb_sad_accumulator;

   localparam int unsigned N    = 32;
   localparam int unsigned BL   = 16;
   localparam int unsigned AW   = 20;
   localparam int unsigned S_BL = 4;
   localparam int unsigned S_AW = 16;

   logic clk = 1'b0;
   logic rst_n;
   logic flush;
   logic flush_s;

   always #5 clk = ~clk;

   sad_accumulator_if #(.N(N)) bus ();
   sad_accumulator_if #(.N(N)) bus_s ();

   sad_accumulator #(.N(N), .BLOCK_LEN(BL), .ACC_W(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus)
   );

   sad_accumulator #(.N(N), .BLOCK_LEN(S_BL), .ACC_W(S_AW)) dut_s (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush_s),
      .bus   (bus_s)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: magnitudes accepted in the current block, and
   // whether a finished result is waiting for the consumer.
   int unsigned m_q[$];
   bit          m_out;

   function automatic longint unsigned sum_q();
      longint unsigned s = 0;
      foreach (m_q[i]) s += m_q[i];
      return s;
   endfunction

   function automatic logic [N-1:0] exp_sad();
      longint unsigned mx = (64'd1 << AW) - 1;
      longint unsigned s  = sum_q();
`ifdef SAD_ACC_SAT_EN
      return N'((s > mx) ? mx : s);
`else
      return N'(s & mx);
`endif
   endfunction

   function automatic logic exp_sat();
`ifdef SAD_ACC_SAT_EN
      return sum_q() > ((64'd1 << AW) - 1);
`else
      return 1'b0;
`endif
   endfunction

   // Drive one cycle on the main instance (entered and left at a negedge)
   // and advance the model by the rules of one clock edge.
   task automatic step(input bit v, input logic [N-1:0] d, input bit ordy,
                       input bit fl, input bit rst);
      bus.in_valid  = v;
      bus.diff      = d;
      bus.out_ready = ordy;
      flush         = fl;
      rst_n         = ~rst;
      @(posedge clk);
      if (rst || fl) begin
         m_q.delete();
         m_out = 0;
      end else if (m_out) begin
         if (ordy) begin
            m_q.delete();
            m_out = 0;
         end
      end else if (v) begin
         m_q.push_back(int'(d[14:0]));
         if (m_q.size() == BL) m_out = 1;
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      step(1, 32'h0000_0010, 0, 0, 1);
      step(1, 32'h0000_0010, 0, 0, 1);
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset out_valid: got %b expected 0", bus.out_valid);
      end
      n_checks++;
      if (bus.sad !== '0) begin
         n_fail++; $display("FAIL reset sad: got %0h expected 0", bus.sad);
      end
      n_checks++;
      if (bus.sad_sat !== 1'b0) begin
         n_fail++; $display("FAIL reset sad_sat: got %b expected 0", bus.sad_sat);
      end
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset in_ready: got %b expected 1", bus.in_ready);
      end
      step(0, '0, 0, 0, 0);
      n_checks++;
      if (bus.sad !== '0) begin
         n_fail++; $display("FAIL reset no_count sad: got %0h expected 0", bus.sad);
      end
   endtask

   task automatic test_saturation();
      logic [N-1:0] e_sad;
      logic         e_sat;
      longint unsigned s;
      bus_s.in_valid  = 1'b1;
      bus_s.diff      = 32'h0000_7FFF;
      bus_s.out_ready = 1'b0;
      s = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         s += 64'h7FFF;
         @(negedge clk);
         if (i == 1) begin
            n_checks++;
            if (bus_s.sad !== 32'h0000_FFFE || bus_s.sad_sat !== 1'b0) begin
               n_fail++; $display("FAIL sat partial: got sad %0h sat %b expected fffe 0",
                                  bus_s.sad, bus_s.sad_sat);
            end
         end
      end
      bus_s.in_valid = 1'b0;
`ifdef SAD_ACC_SAT_EN
      e_sad = N'((s > 64'hFFFF) ? 64'hFFFF : s);
      e_sat = (s > 64'hFFFF);
`else
      e_sad = N'(s % 64'h1_0000);
      e_sat = 1'b0;
`endif
      n_checks++;
      if (bus_s.out_valid !== 1'b1) begin
         n_fail++; $display("FAIL sat out_valid: got %b expected 1", bus_s.out_valid);
      end
      n_checks++;
      if (bus_s.sad !== e_sad) begin
         n_fail++; $display("FAIL sat sad: got %0h expected %0h", bus_s.sad, e_sad);
      end
      n_checks++;
      if (bus_s.sad_sat !== e_sat) begin
         n_fail++; $display("FAIL sat sad_sat: got %b expected %b", bus_s.sad_sat, e_sat);
      end
      bus_s.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus_s.out_ready = 1'b0;
      n_checks++;
      if (bus_s.out_valid !== 1'b0 || bus_s.sad !== '0 || bus_s.sad_sat !== 1'b0) begin
         n_fail++; $display("FAIL sat clear: got valid %b sad %0h sat %b expected 0 0 0",
                            bus_s.out_valid, bus_s.sad, bus_s.sad_sat);
      end
   endtask

   task automatic test_full_block();
      for (int i = 0; i < 16; i++) begin
         step(1, (i % 2 == 0) ? 32'h0000_8005 : 32'h0000_0003, 1, 0, 0);
         n_checks++;
         if (bus.out_valid !== (i == 15)) begin
            n_fail++; $display("FAIL full_block out_valid sample %0d: got %b expected %b",
                               i + 1, bus.out_valid, (i == 15));
         end
      end
      n_checks++;
      if (bus.sad !== 32'd64 || exp_sad() !== 32'd64) begin
         n_fail++; $display("FAIL full_block sad: got %0d model %0d expected 64",
                            bus.sad, exp_sad());
      end
      // Handshake cycle: the offered sample is not taken.
      step(1, 32'h0000_0009, 1, 0, 0);
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.sad !== '0) begin
         n_fail++; $display("FAIL full_block handshake: got valid %b ready %b sad %0h expected 0 1 0",
                            bus.out_valid, bus.in_ready, bus.sad);
      end
      step(1, 32'h0000_0007, 1, 0, 0);
      n_checks++;
      if (bus.sad !== 32'd7) begin
         n_fail++; $display("FAIL full_block next_first: got %0d expected 7", bus.sad);
      end
      step(0, '0, 1, 1, 0);
   endtask

   task automatic test_backpressure();
      logic [N-1:0] held;
      for (int i = 0; i < 16; i++) step(1, $urandom, 0, 0, 0);
      held = exp_sad();
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.sad !== held) begin
         n_fail++; $display("FAIL backpressure result: got valid %b sad %0h expected 1 %0h",
                            bus.out_valid, bus.sad, held);
      end
      for (int i = 0; i < 5; i++) begin
         step(1, $urandom, 0, 0, 0);
         n_checks++;
         if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.sad !== held) begin
            n_fail++; $display("FAIL backpressure hold %0d: got ready %b valid %b sad %0h expected 0 1 %0h",
                               i, bus.in_ready, bus.out_valid, bus.sad, held);
         end
      end
      step(1, $urandom, 1, 0, 0);
      n_checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.sad !== '0) begin
         n_fail++; $display("FAIL backpressure release: got ready %b valid %b sad %0h expected 1 0 0",
                            bus.in_ready, bus.out_valid, bus.sad);
      end
      for (int i = 0; i < 16; i++) step(1, $urandom, 0, 0, 0);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.sad !== exp_sad()) begin
         n_fail++; $display("FAIL backpressure restart: got valid %b sad %0h expected 1 %0h",
                            bus.out_valid, bus.sad, exp_sad());
      end
      step(0, '0, 1, 0, 0);
   endtask

   task automatic test_masking();
      for (int i = 0; i < 16; i++) step(1, 32'hFFFF_8000, 1, 0, 0);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.sad !== '0) begin
         n_fail++; $display("FAIL masking: got valid %b sad %0h expected 1 0",
                            bus.out_valid, bus.sad);
      end
      step(0, '0, 1, 0, 0);
   endtask

   task automatic test_flush();
      for (int i = 0; i < 7; i++) step(1, 32'h0000_0100, 1, 0, 0);
      n_checks++;
      if (bus.sad !== 32'h700) begin
         n_fail++; $display("FAIL flush partial: got %0h expected 700", bus.sad);
      end
      step(1, 32'h0000_0100, 1, 1, 0);
      n_checks++;
      if (bus.sad !== '0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         n_fail++; $display("FAIL flush clear: got sad %0h ready %b valid %b expected 0 1 0",
                            bus.sad, bus.in_ready, bus.out_valid);
      end
      for (int i = 0; i < 16; i++) step(1, 32'h0000_0001, 0, 0, 0);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.sad !== 32'd16) begin
         n_fail++; $display("FAIL flush block: got valid %b sad %0d expected 1 16",
                            bus.out_valid, bus.sad);
      end
      // Flush beats a simultaneous output handshake: the result is dropped.
      step(1, 32'h0000_0005, 1, 1, 0);
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.sad !== '0 || bus.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL flush in_out: got valid %b sad %0h ready %b expected 0 0 1",
                            bus.out_valid, bus.sad, bus.in_ready);
      end
   endtask

   task automatic test_reset_midblock();
      for (int i = 0; i < 5; i++) step(1, $urandom, 1, 0, 0);
      step(1, $urandom, 1, 0, 1);
      n_checks++;
      if (bus.sad !== '0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_mid: got sad %0h ready %b valid %b expected 0 1 0",
                            bus.sad, bus.in_ready, bus.out_valid);
      end
      for (int i = 0; i < 16; i++) step(1, $urandom, 0, 0, 0);
      step(1, $urandom, 0, 0, 1);
      n_checks++;
      if (bus.sad !== '0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_out: got sad %0h ready %b valid %b expected 0 1 0",
                            bus.sad, bus.in_ready, bus.out_valid);
      end
   endtask

   task automatic test_back_to_back();
      int last_rise;
      bit prev_valid;
      last_rise  = -1;
      prev_valid = 0;
      for (int c = 0; c < 3 * (BL + 1); c++) begin
         step(1, $urandom, 1, 0, 0);
         n_checks++;
         if (bus.in_ready !== !m_out || bus.out_valid !== m_out || bus.sad !== exp_sad()) begin
            n_fail++; $display("FAIL b2b cycle %0d: got ready %b valid %b sad %0h expected %b %b %0h",
                               c, bus.in_ready, bus.out_valid, bus.sad, !m_out, m_out, exp_sad());
         end
         if (bus.out_valid === 1'b1 && !prev_valid) begin
            if (last_rise >= 0) begin
               n_checks++;
               if (c - last_rise != BL + 1) begin
                  n_fail++; $display("FAIL b2b period: got %0d expected %0d",
                                     c - last_rise, BL + 1);
               end
            end
            last_rise = c;
         end
         prev_valid = (bus.out_valid === 1'b1);
      end
      step(0, '0, 0, 1, 0);
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
              $urandom_range(0, 39) == 0, 0);
         n_checks++;
         if (bus.in_ready !== !m_out || bus.out_valid !== m_out ||
             bus.sad !== exp_sad() || bus.sad_sat !== exp_sat()) begin
            n_fail++; $display("FAIL random cycle %0d: got ready %b valid %b sad %0h sat %b expected %b %b %0h %b",
                               c, bus.in_ready, bus.out_valid, bus.sad, bus.sad_sat,
                               !m_out, m_out, exp_sad(), exp_sat());
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n           = 1'b0;
      flush           = 1'b0;
      flush_s         = 1'b0;
      bus.in_valid    = 1'b0;
      bus.diff        = '0;
      bus.out_ready   = 1'b0;
      bus_s.in_valid  = 1'b0;
      bus_s.diff      = '0;
      bus_s.out_ready = 1'b0;
      m_out           = 0;
      @(negedge clk);
      test_reset();
      test_saturation();
      test_full_block();
      test_backpressure();
      test_masking();
      test_flush();
      test_reset_midblock();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
